// File: rtl/ternary_mult_seq_pkg.sv
// Shared trit encodings, controller states and the small trit increment
// used to fold the adder carry into the top trit.
package ternary_mult_seq_pkg;

    localparam logic [1:0] T0   = 2'b00;
    localparam logic [1:0] T1   = 2'b01;
    localparam logic [1:0] T2   = 2'b10;
    localparam logic [1:0] TINV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    // t + c for a trit t and a binary carry c; the datapath keeps t + c <= 2
    function automatic logic [1:0] tritAddSmall(input logic [1:0] t, input logic c);
        logic [1:0] r;
        r = t;
        if (c) begin
            case (t)
                T0:      r = T1;
                T1:      r = T2;
                default: r = T2;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ternary_mult_seq_cla.sv
// N-trit unsigned ternary carry-lookahead adder: s, cOut = x + y + cIn.
module ternary_mult_seq_cla #(
    parameter int N = 4
) (
    input  logic [2*N-1:0] x,
    input  logic [2*N-1:0] y,
    input  logic           cIn,
    output logic [2*N-1:0] s,
    output logic           cOut
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    // A trit pair generates a carry when it sums to 3 or 4, propagates on 2
    for (genvar i = 0; i < N; i++) begin : gTrit
        logic [2:0] pairSum;
        logic [2:0] fullSum;
        assign pairSum = {1'b0, x[2*i +: 2]} + {1'b0, y[2*i +: 2]};
        assign g[i]    = (pairSum >= 3'd3);
        assign p[i]    = (pairSum == 3'd2);
        assign fullSum = pairSum + {2'b00, c[i]};
        assign s[2*i +: 2] = (fullSum >= 3'd3) ? 2'(fullSum - 3'd3) : fullSum[1:0];
    end

    always_comb begin
        logic acc;
        acc  = cIn;
        c    = '0;
        c[0] = cIn;
        for (int i = 0; i < N; i++) begin
            acc = cIn;
            for (int j = 0; j <= i; j++) begin
                acc = g[j] | (p[j] & acc);
            end
            c[i+1] = acc;
        end
    end

    assign cOut = c[N];

endmodule

// File: rtl/ternary_mult_seq.sv
// Sequential unsigned ternary multiplier: one multiplier digit per RUN cycle,
// digit 2 taking two passes through the shared HI + A adder.
module ternary_mult_seq
    import ternary_mult_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    output logic           ready,
    output logic           done,
    output logic           err,
    output logic [4*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    stateT          state, nextState;
    logic [2*N-1:0] aReg, hi, lo, sum;
    logic [2*N-1:0] hiNext, loNext;
    logic [1:0]     ctop, d;
    logic [CW-1:0]  cnt;
    logic           flag, carry, errQ;
    logic           anyInv, accept, stepShift, addNow, lastStep;

    ternary_mult_seq_cla #(.N(N)) uAdder (
        .x    (hi),
        .y    (aReg),
        .cIn  (1'b0),
        .s    (sum),
        .cOut (carry)
    );

    always_comb begin
        anyInv = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (a[2*i +: 2] == TINV || b[2*i +: 2] == TINV) anyInv = 1'b1;
        end
    end

    assign d         = lo[1:0];
    assign accept    = (state == IDLE) && start && !anyInv;
    // Digit 2 holds the shift on its first pass while A is added once
    assign stepShift = (d != T2) || flag;
    assign addNow    = (d != T0);
    assign lastStep  = (state == RUN) && stepShift && (cnt == LAST);

    always_comb begin
        if (addNow) begin
            hiNext = {tritAddSmall(ctop, carry), sum[2*N-1:2]};
            loNext = {sum[1:0], lo[2*N-1:2]};
        end else begin
            hiNext = {ctop, hi[2*N-1:2]};
            loNext = {hi[1:0], lo[2*N-1:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (lastStep) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg    <= '0;
            hi      <= '0;
            lo      <= '0;
            ctop    <= T0;
            cnt     <= '0;
            flag    <= 1'b0;
            errQ    <= 1'b0;
            product <= '0;
        end else begin
            errQ <= (state == IDLE) && start && anyInv;
            if (accept) begin
                aReg <= a;
                lo   <= b;
                hi   <= '0;
                ctop <= T0;
                cnt  <= '0;
                flag <= 1'b0;
            end else if (state == RUN) begin
                if (stepShift) begin
                    hi   <= hiNext;
                    lo   <= loNext;
                    ctop <= T0;
                    cnt  <= cnt + 1'b1;
                    flag <= 1'b0;
                    if (lastStep) product <= {hiNext, loNext};
                end else begin
                    hi   <= sum;
                    ctop <= tritAddSmall(ctop, carry);
                    flag <= 1'b1;
                end
            end
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);
    assign err   = errQ;

endmodule

// File: tb/tb_ternary_mult_seq.sv
// Directed bench for ternary_mult_seq (N=4) with hand-computed products.
module tb_ternary_mult_seq;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] a, b;
    logic           ready, done, err;
    logic [4*N-1:0] product;

    int checks = 0;
    int errors = 0;
    int ctopBad = 0;

    ternary_mult_seq #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .err     (err),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dut.ctop == 2'b11) ctopBad++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, product, and the single-cycle done pulse.
    task automatic runMul(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] expProd, input int expCyc, input bit poke);
        int cyc;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, ready}, 32'd0);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (poke) begin
                start = 1'b1; a = 8'hAA; b = 8'hAA;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({tag, "_cycles"}, cyc, expCyc);
        check({tag, "_product"}, {16'd0, product}, {16'd0, expProd});
        @(posedge clk); #1;
        check({tag, "_donepulse"}, {30'd0, done, ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        check("rst_outputs", {29'd0, ready, done, err}, 32'b100);
        check("rst_product", {16'd0, product}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        runMul("m5x7",   8'h06, 8'h09, 16'h004A, 5, 1'b0);
        runMul("m80x80", 8'hAA, 8'hAA, 16'hA901, 8, 1'b0);
        runMul("mbzero", 8'h26, 8'h00, 16'h0000, 4, 1'b0);
        runMul("m1x1",   8'h01, 8'h01, 16'h0001, 4, 1'b0);
        runMul("m80x1",  8'hAA, 8'h01, 16'h00AA, 4, 1'b0);
        runMul("m1x2",   8'h01, 8'h02, 16'h0002, 5, 1'b0);

        // Invalid trit in a: rejected, product keeps 1x2 result
        @(negedge clk);
        a = 8'h03; b = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("inv_err", {30'd0, err, ready}, 32'b11);
        check("inv_product", {16'd0, product}, 32'h0002);
        @(posedge clk); #1;
        check("inv_errpulse", {29'd0, err, done, ready}, 32'b001);
        @(posedge clk); #1;
        check("inv_nodone", {30'd0, done, ready}, 32'b01);

        // Start held during RUN must not disturb the first result
        runMul("poke5x7", 8'h06, 8'h09, 16'h004A, 5, 1'b1);

        // Reset during the second RUN cycle aborts
        @(negedge clk);
        a = 8'h06; b = 8'h09; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_state", {29'd0, ready, done, err}, 32'b100);
        check("abort_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        runMul("post80x80", 8'hAA, 8'hAA, 16'hA901, 8, 1'b0);

        check("ctop_le2", ctopBad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ternary_mult_seq.md
TERNARY_MULT_SEQ -- requirements
Module: ternary_mult_seq

Interface
REQ-001 Parameter N, default 4: operand width in trits; each trit is 2 bits, unsigned ternary, 00=0, 01=1, 10=2, 11=invalid.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only when ready=1.
REQ-005 a  input  2N  multiplicand, sampled on the accepting edge.
REQ-006 b  input  2N  multiplier, sampled on the accepting edge.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 done  output  1  one-cycle pulse: product valid.
REQ-009 err  output  1  one-cycle pulse: request rejected for invalid encoding.
REQ-010 product  output  4N  2N-trit result, held until the next accepted start.

Function
REQ-011 States SHALL be IDLE, RUN and DONE; IDLE->RUN on start with valid operands; RUN->DONE after the last digit step; DONE->IDLE unconditionally after one cycle.
REQ-012 The block SHALL keep these registers: A (N trits), HI (N trits), LO (N trits, loaded with b), CTOP (one trit, 0..2), digit counter (0..N), and a second-pass flag.
REQ-013 On an accepting edge, HI, CTOP, counter and flag SHALL clear, and A<=a, LO<=b.
REQ-014 Each RUN cycle SHALL examine d = LO trit 0, using one shared N-trit ternary adder: s,c = HI + A (cIn=0).
REQ-015 d=0 -> one cycle: shift only.
REQ-016 d=1 -> one cycle: add, then shift.
REQ-017 d=2 -> two cycles: cycle 1 HI<=s, CTOP<=CTOP+c, flag set, no shift; cycle 2 add and shift, flag clear.
REQ-018 Shift with add: HI<={CTOP+c, s trits N-1..1}, LO<={s trit 0, LO trits N-1..1}, CTOP<=0, counter+1.
REQ-019 Shift without add: same as REQ-018 with HI in place of s and c=0.
REQ-020 After the counter reaches N, product SHALL equal {HI,LO}, registered on the RUN->DONE edge.
REQ-021 done SHALL assert exactly N+n2 cycles after the accepting edge, where n2 = number of b trits equal to 2.
REQ-022 If any trit of a or b is 11 when start is sampled in IDLE, err SHALL pulse the next cycle, the state SHALL stay IDLE, and product SHALL be unchanged.
REQ-023 start while not ready SHALL be ignored, with no queuing.
REQ-024 CTOP SHALL never exceed 2, because HI+2A < 3^(N+1).

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE and all registers, including product, SHALL be 0.
REQ-026 Output reset values SHALL be ready=1, done=0, err=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse.

Structure
REQ-028 A shared package SHALL hold the trit encodings (T0, T1, T2, TINV), the state enumeration, and the trit-add-small helper used for CTOP+c.
REQ-029 Exactly one sub-module SHALL be used: the existing N-trit ternary carry-lookahead adder, instantiated once, computing HI+A.

Verification
REQ-030 N=4, a=0x06 (5), b=0x09 (7) -> done 5 cycles after start, product=0x004A (35).
REQ-031 a=0xAA (80), b=0xAA (80) -> done after 8 cycles, product=0xA901 (6400), CTOP never 3.
REQ-032 b=0x00 with any valid a -> done after 4 cycles, product=0x0000.
REQ-033 a=0x03 (invalid trit 0) -> err pulse, ready stays 1, no done, product unchanged.
REQ-034 start re-asserted during RUN -> ignored; the first result completes correctly.
REQ-035 rst_n low at RUN cycle 2 -> next cycle ready=1, product=0, no done; a new request then completes normally.
